// File: rtl/sd_spi_card_responder.sv
// SD SPI-mode card emulator: deframes 48-bit commands on DI, answers R1/R3/R7 on DO.
// Optional CRC7 command checking is enabled by defining SD_RESP_CRC_CHECK_EN.
module sd_spi_card_responder #(
    parameter int          NCR        = 2,
    parameter int          INIT_POLLS = 2,
    parameter logic [31:0] OCR        = 32'h00FF8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DI,
    output logic        DO,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        frame_err,
    output logic        busy,
    output logic        in_idle
);
    localparam int         PW       = $clog2(INIT_POLLS + 2);
    localparam logic [3:0] GAP_LAST = 4'(NCR - 2);

    typedef enum logic [2:0] {HUNT, RECV, CHECK, GAP, SEND} state_t;
    state_t state, state_nxt;

    // frame_sr holds index, arg, crc7 and end bit; the tx bit is checked on the fly
    logic [45:0]   frame_sr;
    logic [5:0]    bit_cnt;
    logic [3:0]    gap_cnt;
    logic [39:0]   resp_sr;
    logic          resp_long;
    logic          app_cmd;
    logic [PW-1:0] poll_cnt;

    logic [5:0]    f_index;
    logic [31:0]   f_arg;
    logic [6:0]    f_crc;
    logic          f_end;
    logic          crc_err;

    assign f_index = frame_sr[45:40];
    assign f_arg   = frame_sr[39:8];
    assign f_crc   = frame_sr[7:1];
    assign f_end   = frame_sr[0];

`ifdef SD_RESP_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc_err = (crc7({2'b01, f_index, f_arg}) != f_crc);
`else
    logic unused_crc;
    assign unused_crc = ^f_crc;
    assign crc_err    = 1'b0;
`endif

    // Command side effects and response word, evaluated while in CHECK
    logic          illegal;
    logic          resp_is_long;
    logic          n_in_idle;
    logic          n_app_cmd;
    logic [PW-1:0] n_poll;
    logic [7:0]    r1;
    logic [39:0]   resp_word;

    always_comb begin
        n_in_idle    = in_idle;
        n_app_cmd    = app_cmd;
        n_poll       = poll_cnt;
        illegal      = 1'b0;
        resp_is_long = 1'b0;
        if (!crc_err) begin
            n_app_cmd = 1'b0;
            case (f_index)
                6'd0: begin
                    n_in_idle = 1'b1;
                    n_poll    = '0;
                end
                6'd8:  resp_is_long = 1'b1;
                6'd16: ;
                6'd55: n_app_cmd = 1'b1;
                6'd41: begin
                    if (!app_cmd)
                        illegal = 1'b1;
                    else if (poll_cnt < PW'(INIT_POLLS)) begin
                        n_poll    = poll_cnt + PW'(1);
                        n_in_idle = 1'b1;
                    end else
                        n_in_idle = 1'b0;
                end
                6'd58: resp_is_long = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
        r1        = {4'b0000, crc_err, illegal, 1'b0, n_in_idle};
        resp_word = {r1, 32'h0};
        if (resp_is_long)
            resp_word = (f_index == 6'd8) ? {r1, 20'h0, 4'h1, f_arg[7:0]}
                                          : {r1, ~n_in_idle, OCR[30:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    // CHECK is the first of the NCR idle cycles, so GAP covers the remaining NCR-1
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: if (!DI) state_nxt = RECV;
            RECV: begin
                if (bit_cnt == 6'd0 && !DI) state_nxt = HUNT;
                else if (bit_cnt == 6'd46)  state_nxt = CHECK;
            end
            CHECK: begin
                if (!f_end)        state_nxt = HUNT;
                else if (NCR == 1) state_nxt = SEND;
                else               state_nxt = GAP;
            end
            GAP:  if (gap_cnt == GAP_LAST) state_nxt = SEND;
            SEND: if (bit_cnt == (resp_long ? 6'd39 : 6'd7)) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_sr  <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            resp_sr   <= '1;
            resp_long <= 1'b0;
            app_cmd   <= 1'b0;
            poll_cnt  <= '0;
            in_idle   <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg   <= '0;
            frame_err <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                HUNT: bit_cnt <= '0;
                RECV: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt != 6'd0) frame_sr <= {frame_sr[44:0], DI};
                end
                CHECK: begin
                    gap_cnt <= '0;
                    bit_cnt <= '0;
                    if (!f_end)
                        frame_err <= 1'b1;
                    else begin
                        cmd_index <= f_index;
                        cmd_arg   <= f_arg;
                        cmd_valid <= !crc_err;
                        in_idle   <= n_in_idle;
                        app_cmd   <= n_app_cmd;
                        poll_cnt  <= n_poll;
                        resp_sr   <= resp_is_long ? resp_word : {resp_word[39:32], 32'hFFFF_FFFF};
                        resp_long <= resp_is_long;
                    end
                end
                GAP:  gap_cnt <= gap_cnt + 4'd1;
                SEND: begin
                    resp_sr <= {resp_sr[38:0], 1'b1};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign DO   = (state == SEND) ? resp_sr[39] : 1'b1;
    assign busy = (state != HUNT);

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed + randomized bench for sd_spi_card_responder against a command-level card model.
module tb_sd_spi_card_responder;
    localparam int          NCR        = 2;
    localparam int          INIT_POLLS = 2;
    localparam logic [31:0] OCR        = 32'h00FF8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        DI = 1'b1;
    logic        DO, cmd_valid, frame_err, busy, in_idle;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    sd_spi_card_responder #(.NCR(NCR), .INIT_POLLS(INIT_POLLS), .OCR(OCR)) dut (
        .clk(clk), .reset(reset), .DI(DI), .DO(DO), .cmd_valid(cmd_valid),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .frame_err(frame_err),
        .busy(busy), .in_idle(in_idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_ferr  = 0;

    // card model state
    bit m_idle  = 1'b1;
    bit m_app   = 1'b0;
    int m_polls = 0;

    always @(negedge clk) begin
        if (cmd_valid) n_valid++;
        if (frame_err) n_ferr++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] r;
        logic       fb;
        r = 7'h0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ r[6];
            r  = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return r;
    endfunction

    function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] arg,
                                          input bit bad_crc, input bit end_bit);
        logic [6:0] c;
        c = crc7({2'b01, idx, arg});
        if (bad_crc) c = c ^ 7'h01;
        return {2'b01, idx, arg, c, end_bit};
    endfunction

    // Returns the response right-aligned in exp, nb = number of response bits.
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                             output logic [39:0] exp, output int nb);
        bit          was_app, ill;
        logic [7:0]  r1;
        logic [31:0] tail;
        ill  = 1'b0;
        tail = 32'h0;
        nb   = 8;
        if (bad_crc) begin
            exp = {32'h0, 8'h08 | 8'(m_idle)};
            return;
        end
        was_app = m_app;
        m_app   = (idx == 6'd55);
        case (idx)
            6'd0:  begin m_idle = 1'b1; m_polls = 0; end
            6'd8:  begin nb = 40; tail = {20'h0, 4'h1, arg[7:0]}; end
            6'd16, 6'd55: ;
            6'd41: begin
                if (!was_app) ill = 1'b1;
                else if (m_polls < INIT_POLLS) m_polls++;
                else m_idle = 1'b0;
            end
            6'd58: nb = 40;
            default: ill = 1'b1;
        endcase
        if (idx == 6'd58) tail = {~m_idle, OCR[30:0]};
        r1 = {5'b0, ill, 1'b0, m_idle};
        exp = (nb == 40) ? {r1, tail} : {32'h0, r1};
    endtask

    task automatic send_bits(input logic [47:0] fr);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            DI = fr[i];
            if (i == 46) chk("busy_at_tx_bit", 40'(busy), 40'h1);
        end
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad_crc,
                          input string tag, output logic [39:0] got);
        logic [39:0] exp;
        int          nb, v0;
        bit          gap_ok;
        v0 = n_valid;
        model_cmd(idx, arg, bad_crc, exp, nb);
        send_bits(frame(idx, arg, bad_crc, 1'b1));
        gap_ok = 1'b1;
        for (int i = 0; i < NCR; i++) begin
            @(negedge clk);
            DI = 1'b1;
            if (DO !== 1'b1) gap_ok = 1'b0;
        end
        chk({tag, "_gap_idle"}, 40'(gap_ok), 40'h1);
        got = '0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            got = {got[38:0], DO};
            if (i == nb - 1) chk({tag, "_busy_last_bit"}, 40'(busy), 40'h1);
        end
        chk({tag, "_resp"}, got, exp);
        @(negedge clk);
        chk({tag, "_busy_after"}, 40'({busy, DO}), 40'h1);
        chk({tag, "_valid_cnt"}, 40'(n_valid - v0), bad_crc ? 40'h0 : 40'h1);
        if (!bad_crc) chk({tag, "_index_arg"}, {2'b0, cmd_index, cmd_arg}, {2'b0, idx, arg});
        chk({tag, "_in_idle"}, 40'(in_idle), 40'(m_idle));
    endtask

    initial begin
        logic [39:0] got;
        logic [5:0]  pick [9];
        int          v0, f0;
        bit          all_one;
        pick = '{6'd0, 6'd8, 6'd16, 6'd55, 6'd41, 6'd55, 6'd58, 6'd17, 6'd24};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_outputs", {33'h0, DO, cmd_valid, frame_err, busy, in_idle, 2'b0},
            {33'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b0});
        chk("rst_index_arg", {2'b0, cmd_index, cmd_arg}, 40'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // T1, T2
        do_cmd(6'd0, 32'h0, 1'b0, "t1_cmd0", got);
        chk("t1_r1_const", got, 40'h01);
        do_cmd(6'd8, 32'h000001AA, 1'b0, "t2_cmd8", got);
        chk("t2_r7_const", got, 40'h01000001AA);

        // T3: initialization polling
        for (int k = 0; k < 3; k++) begin
            do_cmd(6'd55, 32'h0, 1'b0, "t3_cmd55", got);
            do_cmd(6'd41, 32'h40000000, 1'b0, "t3_acmd41", got);
            chk("t3_acmd41_const", got, (k < 2) ? 40'h01 : 40'h00);
        end
        chk("t3_in_idle", 40'(in_idle), 40'h0);
        do_cmd(6'd58, 32'h0, 1'b0, "t3_cmd58", got);
        chk("t3_r3_const", got, 40'h0080FF8000);

        // async reset in the middle of a response
        send_bits(frame(6'd8, 32'h1AA, 1'b0, 1'b1));
        @(negedge clk);
        DI = 1'b1;
        repeat (NCR + 5) @(negedge clk);
        chk("mid_send_busy", 40'(busy), 40'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_send", 40'({DO, busy}), 40'h2);
        @(negedge clk);
        reset = 1'b0;
        m_idle = 1'b1; m_app = 1'b0; m_polls = 0;
        chk("rst_mid_send_idle", 40'({in_idle, cmd_index}), {33'h0, 1'b1, 6'd0});
        repeat (2) @(negedge clk);

        // T4: illegal commands
        do_cmd(6'd17, 32'h0, 1'b0, "t4_cmd17", got);
        chk("t4_cmd17_const", got, 40'h05);
        do_cmd(6'd41, 32'h0, 1'b0, "t4_acmd41_noapp", got);
        chk("t4_noapp_const", got, 40'h05);
        do_cmd(6'd0, 32'h0, 1'b0, "t4_cmd0", got);
        chk("t4_cmd0_const", got, 40'h01);

        // T5: bad end bit
        v0 = n_valid;
        f0 = n_ferr;
        send_bits(frame(6'd0, 32'h0, 1'b0, 1'b0));
        all_one = 1'b1;
        for (int i = 0; i < NCR + 12; i++) begin
            @(negedge clk);
            DI = 1'b1;
            if (DO !== 1'b1) all_one = 1'b0;
        end
        chk("t5_do_idle", 40'(all_one), 40'h1);
        chk("t5_counts", {8'h0, 16'(n_ferr - f0), 16'(n_valid - v0)}, {8'h0, 16'd1, 16'd0});
        do_cmd(6'd0, 32'h0, 1'b0, "t5_cmd0", got);
        chk("t5_cmd0_const", got, 40'h01);

`ifdef SD_RESP_CRC_CHECK_EN
        // T6: corrupted CRC
        do_cmd(6'd0, 32'h0, 1'b1, "t6_badcrc", got);
        chk("t6_const", got, 40'h09);
        do_cmd(6'd55, 32'h0, 1'b0, "t6_cmd55", got);
        do_cmd(6'd41, 32'h0, 1'b1, "t6_acmd41_badcrc", got);
        do_cmd(6'd41, 32'h0, 1'b0, "t6_acmd41", got);
`endif

        // tx bit of 0 is a false start
        @(negedge clk); DI = 1'b0;
        @(negedge clk); DI = 1'b0;
        @(negedge clk); DI = 1'b1;
        repeat (3) @(negedge clk);
        chk("false_start", 40'({busy, DO}), 40'h1);

        // randomized command stream
        for (int n = 0; n < 30; n++) begin
            logic [5:0]  idx;
            logic [31:0] arg;
            idx = pick[$urandom_range(0, 8)];
            arg = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_cmd(idx, arg, 1'b0, "rnd", got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
